usb_fifo_rd_ctrl: RTL
=====================

Name: usb_fifo_rd_ctrl

Overview:
Read-side controller for the USB dual-clock buffer FIFO; lives entirely in the read clock domain and drives the dual-port memory's read address port. It brings the write-domain Gray pointer across the clock boundary with a two-flop synchronizer, keeps the binary/Gray read pointer, and computes empty state and fill level. It accepts read requests from the USB endpoint/packet logic and reports when memory data is valid.

Parameters:
FIFO_WIDTH, 8, data word width (passed through; used for dataOut sizing only)
FIFO_DEPTH, 64, number of words; must equal 2**ADDR_WIDTH
ADDR_WIDTH, 6, memory address width

Ports:
clk  input  1  read-domain clock (same net as memory rdClk)
rst  input  1  asynchronous active-high reset
wrPtrGray  input  ADDR_WIDTH+1  write pointer, Gray coded, from write domain (unsynchronized)
readReq  input  1  consumer requests one word
memData  input  FIFO_WIDTH  memory read data (memory dataOut)
addrOut  output  ADDR_WIDTH  memory read address
rdPtrGray  output  ADDR_WIDTH+1  registered Gray read pointer, to write-domain synchronizer
dataOut  output  FIFO_WIDTH  word to consumer (combinational pass of memData)
dataValid  output  1  dataOut holds the word popped on previous cycle
empty  output  1  no unread words visible in read domain
fillLevel  output  ADDR_WIDTH+1  visible unread word count, 0..FIFO_DEPTH
underflow  output  1  sticky: readReq seen while empty

Behaviour:
- Reset (async assert, sync release by clk): rdPtrBin=0, rdPtrGray=0, both sync stages=0, dataValid=0, underflow=0. Reset outputs: addrOut=0, empty=1, fillLevel=0.
- Synchronizer: wrSync1 <= wrPtrGray; wrSync2 <= wrSync1. Only wrSync2 is used; the latency is 2 clk edges after wrPtrGray becomes stable.
- wrBin = Gray-to-binary(wrSync2): MSB copies; bit i = bit i+1 of wrBin XOR Gray bit i.
- empty = (rdPtrGray == wrSync2), combinational from registers.
- fillLevel = wrBin - rdPtrBin, modulo 2**(ADDR_WIDTH+1); max legal value FIFO_DEPTH.
- pop = readReq & ~empty. On pop: rdPtrBin <= rdPtrBin+1 (wraps at 2**(ADDR_WIDTH+1)); rdPtrGray <= next ^ (next>>1). Both registers update on the same edge.
- addrOut = rdPtrBin[ADDR_WIDTH-1:0]. The memory samples addrOut on the pop edge, so the popped word appears on memData after that edge.
- dataValid <= pop (1-cycle latency). dataOut = memData. Consumer samples dataOut in the cycle where dataValid=1.
- Back-to-back pops are allowed every cycle while ~empty; throughput is 1 word/clk.
- readReq while empty: no pointer change, dataValid=0 next cycle, underflow <= 1. underflow is held until rst.
- Pop on the last visible word: empty asserts in the following cycle unless wrSync2 advances on the same edge.
- Pointer wrap: address wraps 63->0 while the extra MSB toggles, so full (fillLevel=64) and empty stay distinguishable.
- Reset mid-operation: all state clears immediately, and dataValid drops asynchronously. The write side must be reset in the same event; otherwise behaviour is undefined.
- No combinational path from readReq to addrOut. empty and fillLevel do not depend on readReq.

Test Plan:
- Reset: rst=1 -> addrOut=0, empty=1, fillLevel=0, dataValid=0, underflow=0, rdPtrGray=0.
- Sync latency: after reset, drive wrPtrGray=0b0000001 (bin 1) -> empty stays 1 for 2 edges, then empty=0, fillLevel=1.
- Single pop: wrPtrGray=Gray(3) synced, memory preloaded 0xA0,0xA1,0xA2, readReq held 3 cycles -> addrOut 0,1,2; dataValid=1 on the next 3 cycles with dataOut 0xA0,0xA1,0xA2; then empty=1, fillLevel=0.
- Underflow: with empty=1, pulse readReq -> addrOut unchanged, dataValid=0, underflow=1 and stays 1.
- Wrap/full: wrPtrGray=Gray(64) -> fillLevel=64, empty=0. Pop 64 words -> addrOut goes 63->0, rdPtrGray=Gray(64)=0b1100000, empty=1. Then wrPtrGray=Gray(65) -> fillLevel=1 at addrOut 0.
- Async reset mid-stream: assert rst between clk edges during continuous pops -> dataValid=0 and addrOut=0 before the next edge; no pop occurs on that edge.

Source files
------------

// File: rtl/usb_fifo_rd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : usb_fifo_rd_ctrl_if
//  Description : Bus bundle between the USB FIFO read-side controller and
//                the rest of the read clock domain (memory read port and
//                the consumer logic).
//                  wrPtrGray  - write pointer, Gray coded, unsynchronized
//                  readReq    - consumer requests one word
//                  memData    - memory read data
//                  addrOut    - memory read address
//                  rdPtrGray  - registered Gray read pointer
//                  dataOut    - word to consumer
//                  dataValid  - dataOut holds the word popped last cycle
//                  empty      - no unread words visible
//                  fillLevel  - visible unread word count
//                  underflow  - sticky read-while-empty flag
//  Revision    : 1.0  initial release
// ============================================================================
interface usb_fifo_rd_ctrl_if #(
   parameter int FIFO_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
);
   logic [ADDR_WIDTH:0]   wrPtrGray;
   logic                  readReq;
   logic [FIFO_WIDTH-1:0] memData;
   logic [ADDR_WIDTH-1:0] addrOut;
   logic [ADDR_WIDTH:0]   rdPtrGray;
   logic [FIFO_WIDTH-1:0] dataOut;
   logic                  dataValid;
   logic                  empty;
   logic [ADDR_WIDTH:0]   fillLevel;
   logic                  underflow;

   // Environment side: write pointer source, memory and consumer.
   modport master (
      output wrPtrGray, readReq, memData,
      input  addrOut, rdPtrGray, dataOut, dataValid, empty, fillLevel, underflow
   );

   // Read controller side.
   modport slave (
      input  wrPtrGray, readReq, memData,
      output addrOut, rdPtrGray, dataOut, dataValid, empty, fillLevel, underflow
   );
endinterface
`default_nettype wire

// File: rtl/usb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usb_fifo_rd_ctrl
//  Description : Read-side controller of the USB dual-clock buffer FIFO.
//                Synchronizes the write-domain Gray pointer with two flops,
//                keeps the binary/Gray read pointer, derives empty and fill
//                level, and flags valid memory data one cycle after a pop.
//  Ports       : clk  - read-domain clock (memory rdClk)
//                rst  - asynchronous active-high reset
//                bus  - usb_fifo_rd_ctrl_if.slave (pointer, memory and
//                       consumer signals)
//  Revision    : 1.0  initial release
// ============================================================================
module usb_fifo_rd_ctrl #(
   parameter int FIFO_WIDTH = 8,
   parameter int FIFO_DEPTH = 64,
   parameter int ADDR_WIDTH = 6
) (
   input  wire logic         clk,
   input  wire logic         rst,
   usb_fifo_rd_ctrl_if.slave bus
);

   localparam int c_PTR_W = ADDR_WIDTH + 1;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   // The extra pointer MSB is what tells full from empty, so the depth has
   // to be an exact power of two matching the address width.
   if (FIFO_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
      $error("usb_fifo_rd_ctrl: FIFO_DEPTH must equal 2**ADDR_WIDTH");
   end

   logic [c_PTR_W-1:0]    rdPtrBin_q,  rdPtrBin_d;
   logic [c_PTR_W-1:0]    rdPtrGray_q, rdPtrGray_d;
   logic [c_PTR_W-1:0]    wrSync1_q,   wrSync2_q;
   logic                  dataValid_q;
   logic                  underflow_q, underflow_d;
   logic [c_PTR_W-1:0]    wrBin;
   logic                  emptyFlag;
   logic                  pop;
   logic [FIFO_WIDTH-1:0] rdData;

   // Gray to binary: each binary bit is the XOR of all Gray bits at and
   // above it, written as a reduction so no bit depends on another.
   always_comb begin
      wrBin = '0;
      for (int i = 0; i < c_PTR_W; i++) begin
         wrBin[i] = ^(wrSync2_q >> i);
      end
   end

   // Empty and fill level come only from registers; readReq never feeds them.
   assign emptyFlag = (rdPtrGray_q == wrSync2_q);
   assign pop       = bus.readReq & ~emptyFlag;

   always_comb begin
      rdPtrBin_d  = rdPtrBin_q;
      rdPtrGray_d = rdPtrGray_q;
      underflow_d = underflow_q | (bus.readReq & emptyFlag);
      if (pop) begin
         rdPtrBin_d  = rdPtrBin_q + c_PTR_ONE;
         rdPtrGray_d = rdPtrBin_d ^ (rdPtrBin_d >> 1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtrBin_q  <= '0;
         rdPtrGray_q <= '0;
         wrSync1_q   <= '0;
         wrSync2_q   <= '0;
         dataValid_q <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrSync1_q   <= bus.wrPtrGray;
         wrSync2_q   <= wrSync1_q;
         rdPtrBin_q  <= rdPtrBin_d;
         rdPtrGray_q <= rdPtrGray_d;
         dataValid_q <= pop;
         underflow_q <= underflow_d;
      end
   end

   // The memory registers addrOut on the pop edge; its output then carries
   // the popped word during the cycle in which dataValid is high.
   assign rdData        = bus.memData;
   assign bus.dataOut   = rdData;
   assign bus.addrOut   = rdPtrBin_q[ADDR_WIDTH-1:0];
   assign bus.rdPtrGray = rdPtrGray_q;
   assign bus.dataValid = dataValid_q;
   assign bus.empty     = emptyFlag;
   assign bus.fillLevel = wrBin - rdPtrBin_q;
   assign bus.underflow = underflow_q;

endmodule
`default_nettype wire
